// File: rtl/rv32i_memaccess_if.sv
// Pipelined-Wishbone data-bus bundle between the rv32i memory-access stage
// (master) and the data memory or interconnect (slave).
interface rv32i_memaccess_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_data
  );
endinterface

// File: rtl/rv32i_memaccess.sv
// rv32i memory-access stage: turns loads/stores into pipelined-Wishbone cycles,
// passes ALU results through one register, and stalls execute while busy.
module rv32i_memaccess #(
  parameter int MAX_WAIT = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ce,
  input  logic                    i_load,
  input  logic                    i_store,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_y,
  input  logic [31:0]             i_rs2,
  input  logic [4:0]              i_rd_addr,
  input  logic [31:0]             i_rd,
  input  logic                    i_wr_rd,
  input  logic                    i_stall,
  input  logic                    i_flush,
  rv32i_memaccess_if.master       wb,
  output logic                    o_ce,
  output logic [4:0]              o_rd_addr,
  output logic [31:0]             o_rd,
  output logic                    o_wr_rd,
  output logic                    o_stall_from_mem,
  output logic                    o_misaligned,
  output logic                    o_bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic        wr_rd;
    logic        misaligned;
    logic        bus_err;
  } result_t;

  state_t        state, state_d;
  logic [CW-1:0] wait_cnt;
  logic          kill_q;
  logic          store_q;
  logic          buf_valid;
  logic [31:0]   addr_q, data_q;
  logic [3:0]    sel_q;

  // Datapath payload: only meaningful while a control flag marks it valid.
  logic          load_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lo_q;
  logic [4:0]    rd_addr_q;
  result_t       buf_q;

  logic          mem_op, aligned, base_ok;
  logic          accept_mem, accept_mis, accept_alu;
  logic          strobe_taken, bus_ack, timeout, kill;
  logic          res_valid;
  result_t       res;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_data;

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  lo,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  assign mem_op  = i_load | i_store;
  assign aligned = (i_funct3[1:0] == 2'b01) ? ~i_y[0] :
                   (i_funct3[1:0] == 2'b10) ? (i_y[1:0] == 2'b00) : 1'b1;

  // A new instruction is only taken when idle, unflushed, unstalled and with
  // nowhere else for its result to go but the output register.
  assign base_ok    = (state == S_IDLE) & i_ce & ~i_flush & ~i_stall & ~buf_valid;
  assign accept_mem = base_ok & mem_op & aligned;
  assign accept_mis = base_ok & mem_op & ~aligned;
  assign accept_alu = base_ok & ~mem_op;

  assign strobe_taken = (state == S_REQ) & ~wb.i_wb_stall;
  assign bus_ack      = ((state == S_WAIT) | strobe_taken) & wb.i_wb_ack;
  assign timeout      = (state == S_WAIT) & ~wb.i_wb_ack & (wait_cnt == CW'(MAX_WAIT - 1));
  assign kill         = kill_q | i_flush;

  assign o_stall_from_mem = (state != S_IDLE) | buf_valid |
                            (i_ce & mem_op & aligned & ~i_flush);

  assign wb.o_wb_cyc  = (state != S_IDLE);
  assign wb.o_wb_stb  = (state == S_REQ);
  assign wb.o_wb_we   = (state != S_IDLE) & store_q;
  assign wb.o_wb_addr = addr_q;
  assign wb.o_wb_data = data_q;
  assign wb.o_wb_sel  = sel_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    lane_sel  = 4'b1111;
    lane_data = i_rs2;
    if (i_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          lane_sel  = 4'b0001 << i_y[1:0];
          lane_data = {4{i_rs2[7:0]}};
        end
        2'b01: begin
          lane_sel  = i_y[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{i_rs2[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept_mem) state_d = S_REQ;
      S_REQ: begin
        if (wb.i_wb_stall) begin
          if (i_flush) state_d = S_IDLE;
        end else begin
          state_d = wb.i_wb_ack ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: if (bus_ack | timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Exactly one result source can fire per cycle; a killed bus cycle yields none.
  always_comb begin
    res_valid = 1'b0;
    res       = '0;
    if (accept_alu) begin
      res_valid   = 1'b1;
      res.rd_addr = i_rd_addr;
      res.rd      = i_rd;
      res.wr_rd   = i_wr_rd;
    end else if (accept_mis) begin
      res_valid      = 1'b1;
      res.rd_addr    = i_rd_addr;
      res.misaligned = 1'b1;
    end else if (bus_ack & ~kill) begin
      res_valid   = 1'b1;
      res.rd_addr = rd_addr_q;
      res.rd      = load_q ? extract(funct3_q, lo_q, wb.i_wb_data) : 32'd0;
      res.wr_rd   = load_q;
    end else if (timeout & ~kill) begin
      res_valid   = 1'b1;
      res.rd_addr = rd_addr_q;
      res.bus_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      kill_q       <= 1'b0;
      store_q      <= 1'b0;
      buf_valid    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      o_ce         <= 1'b0;
      o_rd_addr    <= '0;
      o_rd         <= '0;
      o_wr_rd      <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + CW'(1) : '0;

      if (accept_mem) begin
        addr_q  <= {i_y[31:2], 2'b00};
        data_q  <= lane_data;
        sel_q   <= lane_sel;
        store_q <= i_store;
        kill_q  <= 1'b0;
      end else if ((state != S_IDLE) && i_flush) begin
        kill_q <= 1'b1;
      end

      if (i_flush)
        buf_valid <= 1'b0;
      else if (res_valid && i_stall)
        buf_valid <= 1'b1;
      else if (!i_stall)
        buf_valid <= 1'b0;

      if (!i_stall) begin
        if (buf_valid && !i_flush) begin
          o_ce         <= 1'b1;
          o_rd_addr    <= buf_q.rd_addr;
          o_rd         <= buf_q.rd;
          o_wr_rd      <= buf_q.wr_rd;
          o_misaligned <= buf_q.misaligned;
          o_bus_err    <= buf_q.bus_err;
        end else if (res_valid) begin
          o_ce         <= 1'b1;
          o_rd_addr    <= res.rd_addr;
          o_rd         <= res.rd;
          o_wr_rd      <= res.wr_rd;
          o_misaligned <= res.misaligned;
          o_bus_err    <= res.bus_err;
        end else begin
          o_ce         <= 1'b0;
          o_wr_rd      <= 1'b0;
          o_misaligned <= 1'b0;
          o_bus_err    <= 1'b0;
        end
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; their valid qualifiers do.
  always_ff @(posedge i_clk) begin
    if (accept_mem) begin
      load_q    <= i_load;
      funct3_q  <= i_funct3;
      lo_q      <= i_y[1:0];
      rd_addr_q <= i_rd_addr;
    end
    if (res_valid && i_stall)
      buf_q <= res;
  end

endmodule

// File: tb/tb_rv32i_memaccess.sv
// Directed bench for rv32i_memaccess: pass-through, byte lanes, load extension,
// misalignment, bus timeout, flushes and the stalled-completion buffer.
module tb_rv32i_memaccess;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ce, i_load, i_store, i_wr_rd, i_stall, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_y, i_rs2, i_rd;
  logic [4:0]  i_rd_addr;
  logic        o_ce, o_wr_rd, o_stall_from_mem, o_misaligned, o_bus_err;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_sel;
  logic        cap_we, cap_stb, stall_all;

  rv32i_memaccess_if wb ();

  rv32i_memaccess #(.MAX_WAIT(15)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ce             (i_ce),
    .i_load           (i_load),
    .i_store          (i_store),
    .i_funct3         (i_funct3),
    .i_y              (i_y),
    .i_rs2            (i_rs2),
    .i_rd_addr        (i_rd_addr),
    .i_rd             (i_rd),
    .i_wr_rd          (i_wr_rd),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .wb               (wb),
    .o_ce             (o_ce),
    .o_rd_addr        (o_rd_addr),
    .o_rd             (o_rd),
    .o_wr_rd          (o_wr_rd),
    .o_stall_from_mem (o_stall_from_mem),
    .o_misaligned     (o_misaligned),
    .o_bus_err        (o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ce = 0; i_load = 0; i_store = 0; i_funct3 = 3'b010; i_y = 0; i_rs2 = 0;
    i_rd_addr = 0; i_rd = 0; i_wr_rd = 0; i_flush = 0;
  endtask

  task automatic drive_mem(input logic st, input logic [2:0] f3, input logic [31:0] y,
                           input logic [31:0] rs2);
    i_ce = 1; i_load = ~st; i_store = st; i_funct3 = f3; i_y = y; i_rs2 = rs2;
    i_rd_addr = 5'd9; i_wr_rd = 1;
  endtask

  // Issue one access, capture the REQ-cycle bus signals, ack after dly bus cycles.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] y,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int dly);
    drive_mem(st, f3, y, rs2);
    tick();
    idle_inputs();
    cap_addr = wb.o_wb_addr; cap_data = wb.o_wb_data; cap_sel = wb.o_wb_sel;
    cap_we = wb.o_wb_we; cap_stb = wb.o_wb_stb;
    stall_all = 1'b1;
    for (int k = 0; k <= dly; k++) begin
      wb.i_wb_ack  = (k == dly);
      wb.i_wb_data = rdata;
      #1 stall_all = stall_all & o_stall_from_mem;
      tick();
    end
    wb.i_wb_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_wait;
    idle_inputs();
    i_stall = 0; wb.i_wb_ack = 0; wb.i_wb_stall = 0; wb.i_wb_data = 0;
    rst_n = 0;
    tick(); tick();
    check("rst_bus", {wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we, wb.o_wb_sel}, 0);
    check("rst_addr_data", wb.o_wb_addr | wb.o_wb_data, 0);
    check("rst_pipe", {o_ce, o_wr_rd, o_misaligned, o_bus_err, o_rd_addr}, 0);
    check("rst_rd", o_rd, 0);
    rst_n = 1;

    // Non-memory pass-through, back-to-back.
    i_ce = 1; i_rd_addr = 5'd5; i_rd = 32'h0000_1234; i_wr_rd = 1;
    #1 check("alu_nostall", o_stall_from_mem, 0);
    tick();
    check("alu1", {o_ce, o_wr_rd, 1'b0, o_rd_addr, o_rd[15:0]}, {1'b1, 1'b1, 1'b0, 5'd5, 16'h1234});
    i_rd_addr = 5'd6; i_rd = 32'h0000_5678;
    tick();
    check("alu2", {o_ce, o_rd_addr, o_rd[15:0]}, {1'b1, 5'd6, 16'h5678});
    idle_inputs();
    tick();
    check("alu_pulse", o_ce, 0);

    // LW 0x100, ack two cycles after the strobe.
    drive_mem(0, 3'b010, 32'h100, 0);
    #1 check("lw_stall_in", o_stall_from_mem, 1);
    idle_inputs();
    access(0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 2);
    check("lw_req", {cap_stb, cap_we, cap_sel}, {1'b1, 1'b0, 4'b1111});
    check("lw_addr", cap_addr, 32'h100);
    check("lw_stall_held", stall_all, 1);
    check("lw_rd", o_rd, 32'hDEAD_BEEF);
    check("lw_ctl", {o_ce, o_wr_rd, o_rd_addr, wb.o_wb_cyc, o_stall_from_mem},
          {1'b1, 1'b1, 5'd9, 1'b0, 1'b0});
    tick();
    check("lw_pulse", o_ce, 0);

    // Load extraction, ack in the accepting REQ cycle.
    access(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0);
    check("lb_rd", o_rd, 32'hFFFF_FF80);
    access(0, 3'b100, 32'h103, 0, 32'h80FF_1234, 0);
    check("lbu_rd", o_rd, 32'h0000_0080);
    access(0, 3'b101, 32'h102, 0, 32'h80FF_1234, 0);
    check("lhu_rd", o_rd, 32'h0000_80FF);
    access(0, 3'b001, 32'h102, 0, 32'h80FF_1234, 1);
    check("lh_rd", o_rd, 32'hFFFF_80FF);
    check("lb_addr_aligned", cap_addr, 32'h100);

    // Stores.
    access(1, 3'b000, 32'h201, 32'h0000_00AB, 0, 1);
    check("sb_addr", cap_addr, 32'h200);
    check("sb_sel_we", {cap_we, cap_sel}, {1'b1, 4'b0010});
    check("sb_data", cap_data, 32'hABAB_ABAB);
    check("sb_done", {o_ce, o_wr_rd}, 2'b10);
    access(1, 3'b001, 32'h202, 32'h1234_CAFE, 0, 0);
    check("sh_sel", cap_sel, 4'b1100);
    check("sh_data", cap_data, 32'hCAFE_CAFE);
    tick();

    // Misaligned SW: no bus cycle, flagged next cycle.
    drive_mem(1, 3'b010, 32'h302, 32'h1);
    #1 check("mis_nostall", o_stall_from_mem, 0);
    tick();
    idle_inputs();
    check("mis_flags", {wb.o_wb_cyc, o_ce, o_misaligned, o_wr_rd, o_bus_err}, 5'b01100);
    tick();
    check("mis_pulse", {o_ce, o_misaligned}, 2'b00);

    // Bus timeout: count WAIT cycles (cyc without stb).
    drive_mem(0, 3'b010, 32'h400, 0);
    tick();
    idle_inputs();
    n_wait = 0;
    for (int g = 0; g < 40 && wb.o_wb_cyc; g++) begin
      if (wb.o_wb_cyc && !wb.o_wb_stb) n_wait++;
      tick();
    end
    check("to_wait_cycles", n_wait, 15);
    check("to_flags", {wb.o_wb_cyc, o_ce, o_bus_err, o_wr_rd}, 4'b0110);
    tick();
    check("to_pulse", {o_ce, o_bus_err}, 2'b00);

    // Flush while the strobe is still stalled.
    wb.i_wb_stall = 1;
    drive_mem(0, 3'b010, 32'h500, 0);
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check("fl_req_held", {wb.o_wb_cyc, wb.o_wb_stb}, 2'b11);
      tick();
    end
    i_flush = 1;
    tick();
    i_flush = 0;
    wb.i_wb_stall = 0;
    check("fl_drop", {wb.o_wb_cyc, wb.o_wb_stb, o_ce}, 3'b000);
    tick();
    check("fl_no_ce", o_ce, 0);

    // Flush after acceptance: cycle completes, result suppressed.
    drive_mem(0, 3'b010, 32'h600, 0);
    tick();
    idle_inputs();
    tick();
    i_flush = 1;
    tick();
    i_flush = 0;
    check("fla_cyc_kept", wb.o_wb_cyc, 1);
    wb.i_wb_ack = 1; wb.i_wb_data = 32'h5555_5555;
    tick();
    wb.i_wb_ack = 0;
    check("fla_suppressed", {wb.o_wb_cyc, o_ce, o_wr_rd}, 3'b000);

    // Ack while the pipeline is stalled: buffered, shown once the stall drops.
    drive_mem(0, 3'b010, 32'h700, 0);
    tick();
    idle_inputs();
    i_stall = 1;
    wb.i_wb_ack = 1; wb.i_wb_data = 32'h1122_3344;
    tick();
    wb.i_wb_ack = 0;
    check("stl_frozen", o_ce, 0);
    check("stl_buf_stall", o_stall_from_mem, 1);
    tick();
    check("stl_still_frozen", o_ce, 0);
    i_stall = 0;
    tick();
    check("stl_present", {o_ce, o_wr_rd}, 2'b11);
    check("stl_rd", o_rd, 32'h1122_3344);
    tick();
    check("stl_pulse", {o_ce, o_stall_from_mem}, 2'b00);

    // Reset mid-transaction drops cyc on the next edge.
    drive_mem(0, 3'b010, 32'h800, 0);
    tick();
    idle_inputs();
    tick();
    rst_n = 0;
    tick();
    check("rst_mid_cyc", {wb.o_wb_cyc, wb.o_wb_addr[11:0]}, 13'd0);
    rst_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_memaccess.md
# rv32i_memaccess

Memory-access stage of the rv32i core, sitting directly downstream of `rv32i_alu`. It consumes the ALU's registered outputs: the effective address, the store data, the writeback fields and the pipeline controls. Loads and stores become pipelined-Wishbone data-bus transactions, with byte lanes and load sign-extension handled here. Non-memory instructions pass straight through a one-cycle pipeline register. While a bus transaction is outstanding, the block stalls the execute stage.

## Interface
Parameters:
- `MAX_WAIT`, default 15: number of cycles spent in WAIT without an ack before the bus-error abort.

Ports (reset is synchronous, active-low):
- `i_clk` in 1: clock.
- `i_rst_n` in 1: synchronous active-low reset.
- `i_ce` in 1: valid instruction from the ALU stage.
- `i_load` in 1: instruction is a load.
- `i_store` in 1: instruction is a store.
- `i_funct3` in 3: access size; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_y` in 32: effective address, or the ALU result for non-memory instructions.
- `i_rs2` in 32: store data.
- `i_rd_addr` in 5: destination register.
- `i_rd` in 32: writeback value for non-load instructions.
- `i_wr_rd` in 1: writeback enable.
- `i_stall` in 1: downstream stall.
- `i_flush` in 1: kill the current instruction.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: bus cycle, strobe, write enable.
- `o_wb_addr` out 32: word-aligned address `{i_y[31:2],2'b00}`.
- `o_wb_data` out 32: store data, lane-replicated.
- `o_wb_sel` out 4: byte enables.
- `i_wb_ack` in 1: bus acknowledge.
- `i_wb_stall` in 1: bus not accepting the strobe.
- `i_wb_data` in 32: read data.
- `o_ce` out 1: valid instruction to writeback.
- `o_rd_addr` out 5: destination register.
- `o_rd` out 32: writeback value.
- `o_wr_rd` out 1: writeback enable.
- `o_stall_from_mem` out 1: stall to the execute stage.
- `o_misaligned` out 1: misaligned-access exception flag, valid with `o_ce`.
- `o_bus_err` out 1: bus-timeout exception flag, valid with `o_ce`.

## Operation
Definitions:
- `mem_op = i_load | i_store`.
- Misaligned if H/HU has `i_y[0]=1`, or W has `i_y[1:0]≠0`.

FSM states: IDLE, REQ, WAIT.
- **IDLE.**
  - If `i_ce & mem_op & ~i_flush & aligned & ~i_stall`: latch address, size, rd_addr, load flag and store data, then go to REQ.
  - If `i_ce & ~mem_op & ~i_flush & ~i_stall`: register `i_rd_addr`, `i_rd` and `i_wr_rd`, and set `o_ce=1` for the next cycle.
  - Misaligned memory op: no bus cycle. Next cycle `o_ce=1`, `o_misaligned=1`, `o_wr_rd=0`.
- **REQ.**
  - Outputs: `o_wb_cyc=o_wb_stb=1`, and `o_wb_we` equals the store flag.
  - If `i_wb_stall`: stay in REQ.
  - Otherwise: go to WAIT, with `o_wb_stb=0` and `o_wb_cyc=1`.
- **WAIT.**
  - On `i_wb_ack`: capture the extracted load data (stores write nothing), go to IDLE, and present the result next cycle with `o_ce=1`. `o_wr_rd=1` for loads, 0 for stores.
  - Timeout counter resets on entry to WAIT. Reaching `MAX_WAIT` without an ack: drop `o_wb_cyc`, go to IDLE, and next cycle `o_ce=1`, `o_bus_err=1`, `o_wr_rd=0`.
  - An ack may arrive in the REQ cycle in which the strobe is accepted; it is treated exactly like an ack in WAIT. An ack in IDLE is ignored.

Byte lanes:
- SB: `sel = 4'b0001 << i_y[1:0]`, data = `{4{rs2[7:0]}}`.
- SH: `sel = i_y[1] ? 4'b1100 : 4'b0011`, data = `{2{rs2[15:0]}}`.
- SW: `sel = 4'b1111`.
- Loads drive `sel = 4'b1111`.

Load extraction uses the latched `i_y[1:0]`:
- LB: sign-extend the selected byte. LBU: zero-extend the selected byte.
- LH: sign-extend the selected halfword. LHU: zero-extend the selected halfword.
- LW: the full word.

Stalls:
- `o_stall_from_mem = (state≠IDLE) | (i_ce & mem_op & aligned & ~i_flush)`, combinational.
- `i_stall=1` freezes all pipeline outputs (`o_ce` included).
- A completion that occurs while `i_stall=1` is held in a one-entry result buffer and presented on the first cycle with `i_stall=0`.
- While that buffer is full, `o_stall_from_mem=1` and no new op is accepted.

Flush:
- In IDLE: the input instruction is dropped.
- In REQ before acceptance (`i_wb_stall=1`): drop cyc/stb and return to IDLE; no `o_ce`.
- Once the strobe has been accepted (REQ with `i_wb_stall=0`, or WAIT): finish the bus cycle but suppress `o_ce` and `o_wr_rd`.
- The flush also clears a pending result-buffer entry.

## Timing
- Reset, synchronous and active-low:
  - State IDLE, counter 0, buffer empty.
  - `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, `o_wb_sel`, `o_wb_addr` and `o_wb_data` all 0.
  - `o_ce`, `o_rd_addr`, `o_rd`, `o_wr_rd`, `o_misaligned` and `o_bus_err` all 0.
  - Reset mid-transaction drops `o_wb_cyc` on the next edge.
- Non-memory op: accepted at edge N, `o_ce=1` in cycle N+1. One-cycle latency, full throughput.
- Memory op with no bus stall, accepted at edge N:
  - REQ in cycle N+1 (`stb` high for one cycle).
  - Earliest ack in cycle N+1.
  - `o_ce` in the cycle after the ack, minimum N+2.
- `o_ce`, `o_misaligned` and `o_bus_err` are single-cycle pulses unless held by `i_stall`.

## Test plan
- LW with `i_y=0x100`, `i_wb_data=0xDEADBEEF`, ack 2 cycles after stb → `sel=1111`, `we=0`, `o_rd=0xDEADBEEF`, `o_wr_rd=1`, `o_stall_from_mem` high until the ack.
- LB at `i_y=0x103` with `i_wb_data=0x80FF1234` → `o_rd=0xFFFFFF80`. LBU at the same address → `0x00000080`. LHU at `0x102` → `0x000080FF`.
- SB at `0x201` with `rs2=0x000000AB` → `addr=0x200`, `sel=0010`, `data=0xABABABAB`, `we=1`, then `o_ce=1` with `o_wr_rd=0`.
- SW at `0x302` → no `cyc`, next-cycle `o_ce=1`, `o_misaligned=1`, `o_wr_rd=0`.
- Load with no ack and `MAX_WAIT=15` → `cyc` drops after 15 WAIT cycles, `o_bus_err=1`.
- `i_wb_stall` held 3 cycles then `i_flush` → `cyc` and `stb` drop, no `o_ce`. Also: ack arriving while `i_stall=1` → result presented the first cycle `i_stall` falls.
